// File: rtl/rv_pkg.sv
// rv_pkg: opcodes, funct3 constants, FSM states and ALU control shared by the core.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // SUB only exists for register-register ops; OP-IMM bit 30 is immediate data.
  function automatic alu_op_t alu_ctrl(input logic [2:0] funct3, input logic funct7b5,
                                       input logic is_op);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_op && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: store lane replication/strobes, load extraction/extension, misalignment.
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);
  logic [31:0] shifted;

  assign shifted = load_word_i >> {addr_lo_i, 3'b000};

  // Replicate store data into every lane and enable only the addressed bytes.
  always_comb begin
    wdata_o = store_data_i;
    wstrb_o = 4'b1111;
    case (funct3_i)
      F3_SB: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      F3_SH: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = 4'b0011 << addr_lo_i;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the word and extend it.
  always_comb begin
    load_data_o = shifted;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

  // Size code 2'b11 has no RV32I access, so it is treated as misaligned.
  always_comb begin
    misaligned_o = 1'b1;
    case (funct3_i[1:0])
      2'b00:   misaligned_o = 1'b0;
      2'b01:   misaligned_o = addr_lo_i[0];
      2'b10:   misaligned_o = (addr_lo_i != 2'b00);
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I core on one valid/ready memory port.
module rv_multicycle_core
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_dbg
);
  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic        pc_upd_q;
  logic [31:0] rf_q [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5, is_legal, is_store, br_taken, lsu_misaligned;
  logic [31:0] rs1_val, rs2_val, imm_d, alu_b, alu_y, aluout_d, pc_plus4;
  logic [31:0] lsu_wdata, mdr_d, wb_data;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  lsu_addr_lo;
  alu_op_t     alu_op;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7b5 = ir_q[30];
  assign is_legal = is_legal_opcode(opcode);
  assign is_store = (opcode == OPC_STORE);
  assign pc_plus4 = pc_q + 32'd4;

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign wb_data = (opcode == OPC_LOAD) ? mdr_q : aluout_q;

  // Register file write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == S_WB && rd != 5'd0) rf_q[rd] <= wb_data;
  end

  // Immediate generator for all instruction formats.
  always_comb begin
    imm_d = {{21{ir_q[31]}}, ir_q[30:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_d = {ir_q[31:12], 12'h000};
      OPC_JAL:    imm_d = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      OPC_BRANCH: imm_d = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_STORE:  imm_d = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
      default: ;
    endcase
  end

  assign alu_b  = (opcode == OPC_OP) ? b_q : imm_q;
  assign alu_op = (opcode == OPC_OP || opcode == OPC_OPIMM) ?
                  alu_ctrl(funct3, funct7b5, opcode == OPC_OP) : ALU_ADD;

  // ALU; shift amounts use only the low five bits.
  always_comb begin
    alu_y = a_q + alu_b;
    case (alu_op)
      ALU_SUB:  alu_y = a_q - alu_b;
      ALU_SLL:  alu_y = a_q << alu_b[4:0];
      ALU_SLT:  alu_y = {31'h0, $signed(a_q) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'h0, a_q < alu_b};
      ALU_XOR:  alu_y = a_q ^ alu_b;
      ALU_SRL:  alu_y = a_q >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(a_q) >>> alu_b[4:0];
      ALU_OR:   alu_y = a_q | alu_b;
      ALU_AND:  alu_y = a_q & alu_b;
      default: ;
    endcase
  end

  // Value latched into ALUOUT at the end of EXEC.
  always_comb begin
    aluout_d = alu_y;
    case (opcode)
      OPC_LUI:           aluout_d = imm_q;
      OPC_AUIPC:         aluout_d = pc_q + imm_q;
      OPC_JAL, OPC_JALR: aluout_d = pc_plus4;
      default: ;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (a_q == b_q);
      F3_BNE:  br_taken = (a_q != b_q);
      F3_BLT:  br_taken = ($signed(a_q) < $signed(b_q));
      F3_BGE:  br_taken = ($signed(a_q) >= $signed(b_q));
      F3_BLTU: br_taken = (a_q < b_q);
      F3_BGEU: br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end

  // EXEC checks alignment on the freshly computed address; MEM uses the latched one.
  assign lsu_addr_lo = (state_q == S_EXEC) ? alu_y[1:0] : aluout_q[1:0];

  rv_lsu_align u_lsu (
    .funct3_i     (funct3),
    .addr_lo_i    (lsu_addr_lo),
    .store_data_i (b_q),
    .load_word_i  (mem_rdata),
    .wdata_o      (lsu_wdata),
    .wstrb_o      (lsu_wstrb),
    .load_data_o  (mdr_d),
    .misaligned_o (lsu_misaligned)
  );

  // Main control FSM with PC, IR and datapath latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      pc_upd_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q      <= rs1_val;
          b_q      <= rs2_val;
          imm_q    <= imm_d;
          pc_upd_q <= 1'b0;
          if (is_legal)             state_q <= S_EXEC;
          else if (TRAP_ON_ILLEGAL) state_q <= S_TRAP;
          else begin
            pc_q    <= pc_plus4;
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          aluout_q <= aluout_d;
          case (opcode)
            OPC_BRANCH: begin
              pc_q    <= br_taken ? pc_q + imm_q : pc_plus4;
              state_q <= S_FETCH;
            end
            OPC_JAL: begin
              pc_q     <= pc_q + imm_q;
              pc_upd_q <= 1'b1;
              state_q  <= S_WB;
            end
            OPC_JALR: begin
              pc_q     <= {alu_y[31:1], 1'b0};
              pc_upd_q <= 1'b1;
              state_q  <= S_WB;
            end
            OPC_LOAD, OPC_STORE: state_q <= lsu_misaligned ? S_TRAP : S_MEM;
            default:             state_q <= S_WB;
          endcase
        end
        S_MEM: if (mem_ready) begin
          if (is_store) begin
            pc_q    <= pc_plus4;
            state_q <= S_FETCH;
          end else begin
            mdr_q   <= mdr_d;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (!pc_upd_q) pc_q <= pc_plus4;
          state_q <= S_FETCH;
        end
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Request is gated by reset so nothing is presented during the reset cycle.
  assign mem_req   = reset_n && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = reset_n && (state_q == S_MEM) && is_store;
  assign mem_addr  = (state_q == S_MEM) ? {aluout_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
  assign mem_wdata = lsu_wdata;
  assign mem_wstrb = mem_we ? lsu_wstrb : 4'b0000;
  assign retire    = reset_n && (
                       (state_q == S_DECODE && !is_legal && !TRAP_ON_ILLEGAL) ||
                       (state_q == S_EXEC && opcode == OPC_BRANCH) ||
                       (state_q == S_MEM && is_store && mem_ready) ||
                       (state_q == S_WB));
  assign halted    = (state_q == S_TRAP);
  assign pc_dbg    = pc_q;

endmodule
